paged_reader_arbiter: RTL and testbench
=======================================

// Module: paged_reader_arbiter
//
// PURPOSE
// Two-requester round-robin scheduler in front of the paged memory reader. Each requester issues
// a command (base address, page count). The block expands it into page addresses on the reader's
// address stream and routes the returned beats to the owning requester. The reader stream carries
// no ID, so a grant is held until the reader's end-of-command tlast.
// Typical users: display scan-out (req 0) and texture/tile loader (req 1).
//
// PARAMETERS
// ADDR_WIDTH      32    width of command addresses and reader address stream
// MEMORY_WIDTH    32    width of reader data beats and requester data outputs
// PAGE_SIZE       2048  bytes per page; must match the reader; power of two, >= 128
// PAGE_CNT_WIDTH  16    width of the per-command page count
//
// PORTS
// aclk            in   1               clock
// resetn          in   1               synchronous reset, active low
// s_cmd0_tvalid   in   1               req 0 command valid
// s_cmd0_tready   out  1               req 0 command accepted (combinational)
// s_cmd0_addr     in   ADDR_WIDTH      req 0 base byte address
// s_cmd0_pages    in   PAGE_CNT_WIDTH  req 0 page count
// s_cmd1_*        --   --              same four signals for req 1
// m_data0_tvalid  out  1               req 0 data beat valid (no backpressure)
// m_data0_tlast   out  1               req 0 last beat of command
// m_data0_tdata   out  MEMORY_WIDTH    req 0 data
// m_data1_*       --   --              same three signals for req 1
// m_addr_tvalid   out  1               page address valid, to reader
// m_addr_tready   in   1               reader accepts address
// m_addr_tlast    out  1               last page of current command
// m_addr_tdata    out  ADDR_WIDTH      page address
// s_rd_tvalid     in   1               beat from reader
// s_rd_tlast      in   1               reader end-of-command
// s_rd_tdata      in   MEMORY_WIDTH    beat data from reader
// busy            out  1               state != IDLE
// grant           out  1               requester currently owning the reader
//
// BEHAVIOUR
// - One clock (aclk); reset is synchronous, active-low (resetn).
// - Reset values: state=IDLE, all tvalid/tlast=0, grant=0, busy=0, lastGrant=1 (req 0 wins first).
// - Handshakes: transfer when valid&&ready. Address outputs are held stable while m_addr_tvalid
//   && !m_addr_tready.
// - IDLE:
//   - sel = the valid requester; if both valid, sel = !lastGrant.
//   - s_cmd<sel>_tready = 1 combinationally; the other tready = 0; both 0 outside IDLE.
//   - On accept: grant<=sel, lastGrant<=sel, curAddr<=addr with low 7 bits forced 0,
//     remaining<=pages.
//   - pages==0 -> command consumed, no reads, stay IDLE, no data output.
//   - else -> ISSUE; m_addr_tvalid rises the cycle after accept.
// - ISSUE:
//   - m_addr_tvalid=1, m_addr_tdata=curAddr, m_addr_tlast=(remaining==1).
//   - On handshake: curAddr += PAGE_SIZE (mod 2^ADDR_WIDTH, wraps silently), remaining -= 1.
//   - If the handshake was the last page: m_addr_tvalid<=0, go DRAIN.
// - DRAIN: wait for s_rd_tvalid && s_rd_tlast, then IDLE. A new command may be accepted the
//   cycle after.
// - Data routing, ISSUE or DRAIN:
//   - s_rd beat at cycle T -> m_data<grant>_tvalid/tdata/tlast registered at T+1.
//   - Other requester's tvalid=0. Shared tdata register allowed.
//   - The beat carrying s_rd_tlast is forwarded with tlast even though the state leaves
//     DRAIN at T+1.
// - s_rd beats arriving in IDLE (protocol violation) are dropped; no output.
// - Simultaneous: a req deasserting tvalid before accept is not granted. s_rd_tlast during ISSUE
//   (reader misuse) is forwarded but does not end the grant.
// - Reset mid-operation: all state cleared, in-flight beats lost. The reader must be reset
//   with the same resetn.
//
// TESTING
// - Single cmd: req0 addr=0x1000_0000, pages=2; ready=1. -> m_addr 0x1000_0000, 0x1000_0800
//   (tlast on 2nd). Each reader beat appears on m_data0 one cycle later; tlast on final beat.
//   m_data1_tvalid never 1.
// - Contention: both valid from reset, 1 page each. -> req0 granted first. req1 accepted only
//   after req0's reader tlast. Next tie goes to req0 again.
// - Backpressure: m_addr_tready toggled 1-of-3 cycles, pages=4 -> exactly 4 addresses, stable
//   while stalled, PAGE_SIZE stride, tlast only on 4th.
// - Edge values: addr=0xFFFF_F87F, pages=2 -> addresses 0xFFFF_F800, 0x0000_0000 (low bits
//   masked, wrap). pages=0 -> tready pulse, no address, stays IDLE.
// - Reset in DRAIN with beats in flight -> next cycle all outputs 0, busy=0. A fresh req1
//   command then completes normally.

Source files
------------

// File: rtl/paged_reader_arbiter.sv
// Two-requester round-robin front end for the paged memory reader: expands a command into page
// addresses and steers the returned beats to the requester that owns the reader.
module paged_reader_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEMORY_WIDTH   = 32,
  parameter int PAGE_SIZE      = 2048,
  parameter int PAGE_CNT_WIDTH = 16
) (
  input  logic                      aclk,
  input  logic                      resetn,
  input  logic                      s_cmd0_tvalid,
  output logic                      s_cmd0_tready,
  input  logic [ADDR_WIDTH-1:0]     s_cmd0_addr,
  input  logic [PAGE_CNT_WIDTH-1:0] s_cmd0_pages,
  input  logic                      s_cmd1_tvalid,
  output logic                      s_cmd1_tready,
  input  logic [ADDR_WIDTH-1:0]     s_cmd1_addr,
  input  logic [PAGE_CNT_WIDTH-1:0] s_cmd1_pages,
  output logic                      m_data0_tvalid,
  output logic                      m_data0_tlast,
  output logic [MEMORY_WIDTH-1:0]   m_data0_tdata,
  output logic                      m_data1_tvalid,
  output logic                      m_data1_tlast,
  output logic [MEMORY_WIDTH-1:0]   m_data1_tdata,
  output logic                      m_addr_tvalid,
  input  logic                      m_addr_tready,
  output logic                      m_addr_tlast,
  output logic [ADDR_WIDTH-1:0]     m_addr_tdata,
  input  logic                      s_rd_tvalid,
  input  logic                      s_rd_tlast,
  input  logic [MEMORY_WIDTH-1:0]   s_rd_tdata,
  output logic                      busy,
  output logic                      grant
);

  localparam logic [ADDR_WIDTH-1:0] PAGE_STEP = ADDR_WIDTH'(PAGE_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = ~ADDR_WIDTH'(127);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  state_e                    state_q, state_d;
  logic                      grant_q, grant_d;
  logic                      last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]     cur_addr_q, cur_addr_d;
  logic [PAGE_CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                      d0_valid_q, d0_valid_d, d1_valid_q, d1_valid_d;
  logic                      d0_last_q, d0_last_d, d1_last_q, d1_last_d;
  logic [MEMORY_WIDTH-1:0]   rdata_q, rdata_d;

  logic                      sel, accept, addr_hs, last_page, beat;
  logic [ADDR_WIDTH-1:0]     cmd_addr;
  logic [PAGE_CNT_WIDTH-1:0] cmd_pages;

  // On a tie the requester that did not win last time is selected.
  always_comb begin
    sel = s_cmd1_tvalid;
    if (s_cmd0_tvalid && s_cmd1_tvalid) sel = ~last_grant_q;
    accept    = (state_q == IDLE) && (s_cmd0_tvalid || s_cmd1_tvalid);
    cmd_addr  = (sel ? s_cmd1_addr : s_cmd0_addr) & LOW_MASK;
    cmd_pages = sel ? s_cmd1_pages : s_cmd0_pages;
    last_page = (remaining_q == PAGE_CNT_WIDTH'(1));
    addr_hs   = (state_q == ISSUE) && m_addr_tready;
    beat      = s_rd_tvalid && (state_q != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (cmd_pages != '0)) state_d = ISSUE;
      ISSUE:   if (addr_hs && last_page) state_d = DRAIN;
      DRAIN:   if (s_rd_tvalid && s_rd_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cur_addr_d   = cur_addr_q;
    remaining_d  = remaining_q;
    if (accept) begin
      grant_d      = sel;
      last_grant_d = sel;
      cur_addr_d   = cmd_addr;
      remaining_d  = cmd_pages;
    end else if (addr_hs) begin
      cur_addr_d  = cur_addr_q + PAGE_STEP;
      remaining_d = remaining_q - PAGE_CNT_WIDTH'(1);
    end
    // The reader carries no ID, so beats always belong to the current grant holder.
    d0_valid_d = beat && !grant_q;
    d1_valid_d = beat && grant_q;
    d0_last_d  = beat && !grant_q && s_rd_tlast;
    d1_last_d  = beat && grant_q && s_rd_tlast;
    rdata_d    = beat ? s_rd_tdata : rdata_q;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cur_addr_q   <= '0;
      remaining_q  <= '0;
      d0_valid_q   <= 1'b0;
      d1_valid_q   <= 1'b0;
      d0_last_q    <= 1'b0;
      d1_last_q    <= 1'b0;
      rdata_q      <= '0;
    end else begin
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cur_addr_q   <= cur_addr_d;
      remaining_q  <= remaining_d;
      d0_valid_q   <= d0_valid_d;
      d1_valid_q   <= d1_valid_d;
      d0_last_q    <= d0_last_d;
      d1_last_q    <= d1_last_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    s_cmd0_tready  = accept && !sel;
    s_cmd1_tready  = accept && sel;
    m_addr_tvalid  = (state_q == ISSUE);
    m_addr_tlast   = (state_q == ISSUE) && last_page;
    m_addr_tdata   = cur_addr_q;
    m_data0_tvalid = d0_valid_q;
    m_data0_tlast  = d0_last_q;
    m_data0_tdata  = rdata_q;
    m_data1_tvalid = d1_valid_q;
    m_data1_tlast  = d1_last_q;
    m_data1_tdata  = rdata_q;
    busy           = (state_q != IDLE);
    grant          = grant_q;
  end

endmodule

// File: tb/tb_paged_reader_arbiter.sv
// Randomized bench for paged_reader_arbiter: a transaction-level model predicts arbitration,
// page addresses and beat routing, and every DUT output is compared against it each cycle.
module tb_paged_reader_arbiter;
  localparam int AW = 32;
  localparam int MW = 32;
  localparam int PS = 2048;
  localparam int PW = 16;

  logic          aclk = 1'b0;
  logic          resetn = 1'b0;
  logic          s_cmd0_tvalid = 1'b0, s_cmd0_tready;
  logic [AW-1:0] s_cmd0_addr = '0;
  logic [PW-1:0] s_cmd0_pages = '0;
  logic          s_cmd1_tvalid = 1'b0, s_cmd1_tready;
  logic [AW-1:0] s_cmd1_addr = '0;
  logic [PW-1:0] s_cmd1_pages = '0;
  logic          m_data0_tvalid, m_data0_tlast, m_data1_tvalid, m_data1_tlast;
  logic [MW-1:0] m_data0_tdata, m_data1_tdata;
  logic          m_addr_tvalid, m_addr_tlast;
  logic          m_addr_tready = 1'b0;
  logic [AW-1:0] m_addr_tdata;
  logic          s_rd_tvalid = 1'b0, s_rd_tlast = 1'b0;
  logic [MW-1:0] s_rd_tdata = '0;
  logic          busy, grant;

  always #5 aclk = ~aclk;

  paged_reader_arbiter #(.ADDR_WIDTH(AW), .MEMORY_WIDTH(MW), .PAGE_SIZE(PS), .PAGE_CNT_WIDTH(PW)) dut (
    .aclk(aclk), .resetn(resetn),
    .s_cmd0_tvalid(s_cmd0_tvalid), .s_cmd0_tready(s_cmd0_tready),
    .s_cmd0_addr(s_cmd0_addr), .s_cmd0_pages(s_cmd0_pages),
    .s_cmd1_tvalid(s_cmd1_tvalid), .s_cmd1_tready(s_cmd1_tready),
    .s_cmd1_addr(s_cmd1_addr), .s_cmd1_pages(s_cmd1_pages),
    .m_data0_tvalid(m_data0_tvalid), .m_data0_tlast(m_data0_tlast), .m_data0_tdata(m_data0_tdata),
    .m_data1_tvalid(m_data1_tvalid), .m_data1_tlast(m_data1_tlast), .m_data1_tdata(m_data1_tdata),
    .m_addr_tvalid(m_addr_tvalid), .m_addr_tready(m_addr_tready),
    .m_addr_tlast(m_addr_tlast), .m_addr_tdata(m_addr_tdata),
    .s_rd_tvalid(s_rd_tvalid), .s_rd_tlast(s_rd_tlast), .s_rd_tdata(s_rd_tdata),
    .busy(busy), .grant(grant)
  );

  int total = 0;
  int bad = 0;

  // Reference model: who owns the reader, which page addresses are still owed, what beat is due.
  bit            m_busy, m_owner, m_last;
  logic [AW-1:0] addr_q[$];
  logic [AW-1:0] seen_addr[$];
  bit            hold[2];
  logic [AW-1:0] c_addr[2];
  logic [PW-1:0] c_pages[2];
  bit            gen_en, bp_mode;
  int            bp_cnt;
  bit            rd_active, rd_addr_done;
  int            rd_beats_left;
  bit            e_dv[2], e_dl[2];
  logic [MW-1:0] e_dd;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] pickAddr();
    case ($urandom_range(0, 2))
      0:       return AW'($urandom);
      1:       return 32'hFFFF_F000 | AW'($urandom_range(0, 4095));
      default: return AW'($urandom) & 32'h00FF_FFFF;
    endcase
  endfunction

  task automatic clearModel();
    m_busy = 0; m_owner = 0; m_last = 1;
    addr_q.delete();
    hold[0] = 0; hold[1] = 0;
    rd_active = 0; rd_addr_done = 0; rd_beats_left = 0;
    e_dv[0] = 0; e_dv[1] = 0; e_dl[0] = 0; e_dl[1] = 0; e_dd = '0;
  endtask

  task automatic applyStimulus(input int r, input logic [AW-1:0] addr, input logic [PW-1:0] pages);
    hold[r]    = 1;
    c_addr[r]  = addr;
    c_pages[r] = pages;
  endtask

  task automatic step();
    bit            any, sel, idle_now, beat_ok;
    logic [AW-1:0] base;
    @(negedge aclk);
    for (int r = 0; r < 2; r++)
      if (gen_en && !hold[r] && $urandom_range(0, 2) == 0)
        applyStimulus(r, pickAddr(), PW'($urandom_range(0, 3)));
    s_cmd0_tvalid = hold[0]; s_cmd0_addr = c_addr[0]; s_cmd0_pages = c_pages[0];
    s_cmd1_tvalid = hold[1]; s_cmd1_addr = c_addr[1]; s_cmd1_pages = c_pages[1];
    if (bp_mode) begin
      bp_cnt++;
      m_addr_tready = (bp_cnt % 3 == 0);
    end else begin
      m_addr_tready = ($urandom_range(0, 3) != 0);
    end
    s_rd_tvalid = 0; s_rd_tlast = 0; s_rd_tdata = MW'($urandom);
    if (rd_active) begin
      if (rd_addr_done && rd_beats_left == 0) begin
        if ($urandom_range(0, 1) == 1) begin s_rd_tvalid = 1; s_rd_tlast = 1; end
      end else if ($urandom_range(0, 1) == 1) begin
        s_rd_tvalid = 1;
        if (rd_addr_done) rd_beats_left--;
      end
    end else if (gen_en && $urandom_range(0, 7) == 0) begin
      s_rd_tvalid = 1; s_rd_tlast = 1'($urandom_range(0, 1));
    end
    #1;
    idle_now = !m_busy;
    any = hold[0] || hold[1];
    sel = (hold[0] && hold[1]) ? !m_last : hold[1];
    checkOutput("cmd0_ready", s_cmd0_tready, idle_now && any && !sel);
    checkOutput("cmd1_ready", s_cmd1_tready, idle_now && any && sel);
    checkOutput("busy", busy, m_busy);
    checkOutput("grant", grant, m_owner);
    checkOutput("addr_valid", m_addr_tvalid, addr_q.size() > 0);
    if (addr_q.size() > 0) begin
      checkOutput("addr_data", m_addr_tdata, addr_q[0]);
      checkOutput("addr_last", m_addr_tlast, addr_q.size() == 1);
    end
    checkOutput("d0_valid", m_data0_tvalid, e_dv[0]);
    checkOutput("d1_valid", m_data1_tvalid, e_dv[1]);
    if (e_dv[0]) begin
      checkOutput("d0_data", m_data0_tdata, e_dd);
      checkOutput("d0_last", m_data0_tlast, e_dl[0]);
    end
    if (e_dv[1]) begin
      checkOutput("d1_data", m_data1_tdata, e_dd);
      checkOutput("d1_last", m_data1_tlast, e_dl[1]);
    end
    if (m_addr_tvalid && m_addr_tready) seen_addr.push_back(m_addr_tdata);

    beat_ok = s_rd_tvalid && m_busy;
    e_dv[0] = beat_ok && !m_owner;
    e_dv[1] = beat_ok && m_owner;
    e_dl[0] = e_dv[0] && s_rd_tlast;
    e_dl[1] = e_dv[1] && s_rd_tlast;
    e_dd    = s_rd_tdata;
    if (m_busy) begin
      if (addr_q.size() > 0) begin
        if (m_addr_tready) begin
          void'(addr_q.pop_front());
          rd_active = 1;
          if (addr_q.size() == 0) begin
            rd_addr_done  = 1;
            rd_beats_left = $urandom_range(0, 2);
          end
        end
      end else if (s_rd_tvalid && s_rd_tlast) begin
        m_busy = 0; rd_active = 0; rd_addr_done = 0;
      end
    end else if (any) begin
      hold[sel] = 0;
      m_owner = sel;
      m_last  = sel;
      if (c_pages[sel] != 0) begin
        m_busy = 1;
        base = c_addr[sel] & ~AW'(127);
        for (int i = 0; i < int'(c_pages[sel]); i++) addr_q.push_back(base + AW'(i * PS));
      end
    end
  endtask

  task automatic doReset(input bit beats_in_flight);
    @(negedge aclk);
    resetn = 0;
    s_cmd0_tvalid = 0; s_cmd1_tvalid = 0;
    m_addr_tready = 1'($urandom);
    s_rd_tvalid = beats_in_flight; s_rd_tlast = 0; s_rd_tdata = MW'($urandom);
    @(negedge aclk);
    s_rd_tvalid = 0;
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_addr_valid", m_addr_tvalid, 0);
    checkOutput("rst_addr_last", m_addr_tlast, 0);
    checkOutput("rst_d0_valid", m_data0_tvalid, 0);
    checkOutput("rst_d0_last", m_data0_tlast, 0);
    checkOutput("rst_d1_valid", m_data1_tvalid, 0);
    checkOutput("rst_d1_last", m_data1_tlast, 0);
    resetn = 1;
    clearModel();
  endtask

  task automatic runUntilIdle(input int max_cycles);
    int n = 0;
    do begin
      step();
      n++;
    end while ((m_busy || hold[0] || hold[1]) && n < max_cycles);
    checkOutput("idle_reached", !(m_busy || hold[0] || hold[1]), 1);
    step();
    step();
  endtask

  initial begin
    int n;
    gen_en = 0; bp_mode = 0; bp_cnt = 0;
    clearModel();
    doReset(0);

    applyStimulus(0, 32'h1000_0000, 2);
    seen_addr.delete();
    runUntilIdle(200);
    checkOutput("single_count", seen_addr.size(), 2);
    if (seen_addr.size() == 2) begin
      checkOutput("single_a0", seen_addr[0], 32'h1000_0000);
      checkOutput("single_a1", seen_addr[1], 32'h1000_0800);
    end

    doReset(0);
    applyStimulus(0, 32'h0000_4000, 1);
    applyStimulus(1, 32'h0008_0000, 1);
    runUntilIdle(200);
    applyStimulus(0, 32'h0000_6000, 1);
    applyStimulus(1, 32'h000A_0000, 1);
    runUntilIdle(200);

    bp_mode = 1; bp_cnt = 0;
    applyStimulus(1, pickAddr(), 4);
    seen_addr.delete();
    runUntilIdle(300);
    bp_mode = 0;
    checkOutput("bp_count", seen_addr.size(), 4);

    applyStimulus(0, 32'hFFFF_F87F, 2);
    seen_addr.delete();
    runUntilIdle(200);
    checkOutput("wrap_count", seen_addr.size(), 2);
    if (seen_addr.size() == 2) begin
      checkOutput("wrap_a0", seen_addr[0], 32'hFFFF_F800);
      checkOutput("wrap_a1", seen_addr[1], 32'h0000_0000);
    end

    applyStimulus(1, pickAddr(), 0);
    seen_addr.delete();
    runUntilIdle(50);
    checkOutput("zero_pages_count", seen_addr.size(), 0);

    gen_en = 1;
    repeat (800) step();
    gen_en = 0;
    runUntilIdle(500);

    applyStimulus(0, 32'h2000_0000, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (!(m_busy && addr_q.size() == 0) && n < 100);
    checkOutput("drain_reached", m_busy && addr_q.size() == 0, 1);
    doReset(1);
    applyStimulus(1, 32'h3000_0040, 2);
    seen_addr.delete();
    runUntilIdle(200);
    checkOutput("post_rst_count", seen_addr.size(), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
